// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer with single outstanding request
//
// Purpose:
//   Walks a program counter through instruction memory, one request in
//   flight at a time, and presents each returned word in a one-entry
//   output buffer. It also handles branch redirects, discards stale
//   responses and stops cleanly on halt.
//
// Optional build macro:
//   FETCH_SEQ_PERF_EN - adds perf_fetch_cnt, a saturating 16-bit count of
//                       instructions accepted downstream.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   run, halt          start fetching (level) / stop after outstanding fetch (level)
//   branch_valid       one-cycle redirect strobe, branch_target sampled with it
//   imem_req/addr/gnt  memory request, address, accept
//   imem_rvalid/rdata  memory read response
//   instr_valid/data/pc/ready  output instruction buffer and downstream accept
//   pc                 current fetch PC
//   busy               1 whenever the sequencer is not idle
//   perf_fetch_cnt     accepted-instruction count (FETCH_SEQ_PERF_EN only)

module fetch_sequencer #(
  parameter int ADDR_W  = 9,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               halt,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [15:0]        perf_fetch_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [ADDR_W-1:0]  req_pc;
  logic               discard;
  logic               halt_pend;

  logic               xfer;
  logic               accept;
  logic               fill;
  logic               halt_any;
  logic               set_discard;

  // Request handshake completes this cycle.
  assign xfer     = imem_req & imem_gnt;
  // Downstream takes the buffered instruction this cycle.
  assign accept   = instr_valid & instr_ready;
  // A live response is written to the buffer; a redirect in the same cycle
  // wins and the response is simply dropped.
  assign fill     = (state == S_WAIT) & imem_rvalid & ~discard & ~branch_valid;
  assign halt_any = halt | halt_pend;

  // A redirect orphans the request in flight. If its response lands in the
  // same cycle as the redirect there is nothing left to wait for, so the
  // flag is only needed when the response is still to come.
  assign set_discard = branch_valid &
                       (((state == S_WAIT) & ~imem_rvalid) | xfer);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    if (branch_valid) begin
      // Redirect restarts fetching from the new PC, except when idle where
      // it only preloads the PC.
      state_next = (state == S_IDLE) ? S_IDLE : S_FETCH;
    end else begin
      case (state)
        S_IDLE: begin
          if (run && !halt) begin
            state_next = S_FETCH;
          end
        end
        S_FETCH: begin
          if (xfer) begin
            state_next = S_WAIT;
          end else if (halt_any) begin
            state_next = S_IDLE;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state_next = halt_any ? S_IDLE : S_FETCH;
          end
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = '0;
    busy      = (state != S_IDLE);
    // Request only when the buffer can take the answer (empty or draining
    // now) and no orphaned response is still due back.
    if ((state == S_FETCH) && !discard && (!instr_valid || instr_ready)) begin
      imem_req = 1'b1;
    end
    if (imem_req) begin
      imem_addr = pc;
    end
  end

  // ---------------------------------------------------------------------
  // PC, request tracking and output buffer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= '0;
      req_pc      <= '0;
      instr_valid <= 1'b0;
      instr_data  <= '0;
      instr_pc    <= '0;
      discard     <= 1'b0;
      halt_pend   <= 1'b0;
    end else begin
      if (xfer) begin
        req_pc <= pc;
      end

      // PC advances only when a response is accepted into the buffer; it
      // wraps naturally at 2^ADDR_W.
      if (branch_valid) begin
        pc <= branch_target;
      end else if (fill) begin
        pc <= req_pc + ADDR_W'(1);
      end

      // An idle redirect only preloads the PC and leaves the buffer alone.
      if (branch_valid && (state != S_IDLE)) begin
        instr_valid <= 1'b0;
      end else if (fill) begin
        instr_valid <= 1'b1;
        instr_data  <= imem_rdata;
        instr_pc    <= req_pc;
      end else if (accept) begin
        instr_valid <= 1'b0;
      end

      // Any response arriving while discard is set is the orphaned one.
      if (set_discard) begin
        discard <= 1'b1;
      end else if (imem_rvalid) begin
        discard <= 1'b0;
      end

      if (state_next == S_IDLE) begin
        halt_pend <= 1'b0;
      end else if (halt) begin
        halt_pend <= 1'b1;
      end
    end
  end

`ifdef FETCH_SEQ_PERF_EN
  // ---------------------------------------------------------------------
  // Accepted-instruction counter, sticks at all-ones
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_cnt <= '0;
    end else if (accept && (perf_fetch_cnt != 16'hFFFF)) begin
      perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter ADDR_W, default 9, SHALL set the PC and instruction-address width.
REQ-002 Parameter INSTR_W, default 16, SHALL set the instruction word width.
REQ-003 clk  input  1  SHALL be the clock; all state updates on the rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 run  input  1  SHALL be a level; 1 in IDLE starts fetching.
REQ-006 halt  input  1  SHALL be a level; 1 requests stop after the outstanding fetch.
REQ-007 branch_valid  input  1  SHALL be a one-cycle PC redirect strobe.
REQ-008 branch_target  input  ADDR_W  SHALL be the redirect address, sampled when branch_valid=1.
REQ-009 imem_req  output  1  SHALL be the instruction-memory read request.
REQ-010 imem_addr  output  ADDR_W  SHALL be the request address, equal to pc while imem_req=1.
REQ-011 imem_gnt  input  1  SHALL be the memory accept; a request transfers when imem_req & imem_gnt.
REQ-012 imem_rvalid / imem_rdata  input  1 / INSTR_W  SHALL be the read response, at least one cycle after grant.
REQ-013 instr_valid / instr_data / instr_pc  output  1 / INSTR_W / ADDR_W  SHALL be the output instruction buffer.
REQ-014 instr_ready  input  1  SHALL be the downstream accept; transfer when instr_valid & instr_ready.
REQ-015 pc  output  ADDR_W  SHALL be the current fetch PC.
REQ-016 busy  output  1  SHALL be 1 whenever state is not IDLE.

Function
REQ-017 FSM states: IDLE, FETCH, WAIT; one outstanding memory request at most.
REQ-018 IDLE: imem_req=0; run=1 and halt=0 -> FETCH next cycle.
REQ-019 FETCH: imem_req=1 only when instr_valid=0 or the buffer drains that cycle; grant -> WAIT, pc unchanged; request address latched as req_pc.
REQ-020 WAIT: imem_req=0; on imem_rvalid, instr_data<=imem_rdata, instr_pc<=req_pc, instr_valid<=1, pc<=req_pc+1; then FETCH, or IDLE if halt pending.
REQ-021 PC arithmetic SHALL be modulo 2^ADDR_W (511+1 -> 0 at default).
REQ-022 instr_valid SHALL stay 1 with data stable until accepted; acceptance with no same-cycle fill clears it.
REQ-023 branch_valid=1 SHALL set pc<=branch_target, clear instr_valid, and in any non-IDLE state go to FETCH next cycle.
REQ-024 Branch in WAIT, or in FETCH coincident with grant, SHALL set a discard flag; the matching response is dropped: no buffer write, no pc change, FSM -> FETCH.
REQ-025 While discard is set, FETCH SHALL NOT issue a new request until the dropped response arrives.
REQ-026 Priority: reset > branch_valid > halt > normal sequencing.
REQ-027 halt=1 SHALL latch halt-pending; FETCH with no grant that cycle -> IDLE; WAIT completes its response, then -> IDLE; pending clears on entering IDLE.
REQ-028 branch_valid in IDLE SHALL load pc only; state remains IDLE.

Reset
REQ-029 reset SHALL force IDLE, pc=0, imem_req=0, imem_addr=0, instr_valid=0, instr_data=0, instr_pc=0, busy=0, discard=0, halt-pending=0.
REQ-030 reset mid-WAIT SHALL abandon the outstanding request; a later imem_rvalid SHALL be ignored until the next grant.

Configuration
REQ-031 Macro FETCH_SEQ_PERF_EN defined: adds output perf_fetch_cnt (16 bits), incremented on each instr_valid & instr_ready, saturating at 0xFFFF, cleared by reset.
REQ-032 Macro undefined: port perf_fetch_cnt and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-033 Reset, run=1, gnt=1, rvalid one cycle after grant, ready=1 -> instr_pc 0,1,2 with matching data; pc ends at 3.
REQ-034 pc=511, fetch completes -> instr_pc=511, pc=0.
REQ-035 instr_ready=0 with buffer full -> imem_req=0, instr_data stable; ready=1 -> transfer, request resumes next cycle.
REQ-036 branch_valid, target 0x40, in WAIT -> stale response dropped, instr_valid=0; next delivered instr_pc=0x40.
REQ-037 halt=1 in WAIT -> response delivered, then IDLE, busy=0, imem_req=0 while halt=1.
REQ-038 With FETCH_SEQ_PERF_EN: 3 accepted instructions -> perf_fetch_cnt=3; reset -> 0.
